// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: pass/load/zero/store against an internal single-port memory,
// one-cycle registered result to WB. Define MEM_CLEAR_EN to zero the memory after reset.
module mem_stage_pipe #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned CTRL_W = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iValidEX,
   input  logic [DATA_W-1:0] iAluDataEX,
   input  logic [1:0]        iOutMemSelect,
   input  logic [ADDR_W-1:0] iAddresReadNWrite,
   input  logic [CTRL_W-1:0] iControlAcum_EX,
   input  logic              iStallWB,
   output logic              oStallMEM,
   output logic              oValidMEM,
   output logic [DATA_W-1:0] oDataToWB,
   output logic [CTRL_W-1:0] oControlAcum_MEM,
   output logic              oAddrFault
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] SEL_PASS  = 2'd0;
   localparam logic [1:0] SEL_LOAD  = 2'd1;
   localparam logic [1:0] SEL_ZERO  = 2'd2;
   localparam logic [1:0] SEL_STORE = 2'd3;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic              fault_q, fault_d;

   logic              stall_c;
   logic              accept_c;
   logic              fault_c;
   logic [IDX_W-1:0]  mem_idx_c;
   logic              mem_we_c;
   logic [IDX_W-1:0]  mem_waddr_c;
   logic [DATA_W-1:0] mem_wdata_c;

`ifdef MEM_CLEAR_EN
   typedef enum logic {S_CLEAR, S_RUN} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q,   ptr_d;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign stall_c = (state_q == S_CLEAR) | iStallWB;
`else
   assign stall_c = iStallWB;
`endif

   // Out-of-range addresses fault; compared one bit wider so DEPTH == 2**ADDR_W never faults
   assign fault_c   = ({1'b0, iAddresReadNWrite} >= (ADDR_W + 1)'(DEPTH));
   assign accept_c  = iValidEX & ~stall_c;
   assign mem_idx_c = IDX_W'(iAddresReadNWrite);

   always_comb begin
      valid_d     = valid_q;
      data_d      = data_q;
      ctrl_d      = ctrl_q;
      fault_d     = fault_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = mem_idx_c;
      mem_wdata_c = iAluDataEX;
`ifdef MEM_CLEAR_EN
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == S_CLEAR) begin
         mem_we_c    = 1'b1;
         mem_waddr_c = ptr_q;
         mem_wdata_c = '0;
         ptr_d       = ptr_q + IDX_W'(1);
         if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_d = S_RUN;
         end
      end
`endif
      if (accept_c) begin
         valid_d = 1'b1;
         ctrl_d  = iControlAcum_EX;
         fault_d = fault_c;
         case (iOutMemSelect)
            SEL_PASS: data_d = iAluDataEX;
            SEL_LOAD: data_d = fault_c ? '0 : mem_q[mem_idx_c];
            SEL_ZERO: data_d = '0;
            SEL_STORE: begin
               data_d   = iAluDataEX;
               mem_we_c = ~fault_c;
            end
            default: data_d = data_q;
         endcase
      end else if (!stall_c) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         fault_q <= fault_d;
      end
   end

   // Write lands at the store's edge so a following load sees it
   always_ff @(posedge Clock) begin
      if (mem_we_c) begin
         mem_q[mem_waddr_c] <= mem_wdata_c;
      end
   end

   assign oStallMEM        = stall_c;
   assign oValidMEM        = valid_q;
   assign oDataToWB        = data_q;
   assign oControlAcum_MEM = ctrl_q;
   assign oAddrFault       = fault_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: two instances (DEPTH 1024 and 600) share stimulus;
// a DEPTH 16 instance is added when MEM_CLEAR_EN is defined.
module tb_mem_stage_pipe;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       iValidEX = 1'b0;
   logic [7:0] iAluDataEX = '0;
   logic [1:0] iOutMemSelect = '0;
   logic [9:0] iAddresReadNWrite = '0;
   logic [2:0] iControlAcum_EX = '0;
   logic       iStallWB = 1'b0;

   logic       stall_b, valid_b, fault_b;
   logic [7:0] data_b;
   logic [2:0] ctrl_b;
   logic       stall_s, valid_s, fault_s;
   logic [7:0] data_s;
   logic [2:0] ctrl_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clock = ~Clock;

   mem_stage_pipe #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .CTRL_W(3)) u_big (
      .Clock(Clock), .Reset(Reset), .iValidEX(iValidEX), .iAluDataEX(iAluDataEX),
      .iOutMemSelect(iOutMemSelect), .iAddresReadNWrite(iAddresReadNWrite),
      .iControlAcum_EX(iControlAcum_EX), .iStallWB(iStallWB), .oStallMEM(stall_b),
      .oValidMEM(valid_b), .oDataToWB(data_b), .oControlAcum_MEM(ctrl_b), .oAddrFault(fault_b));

   mem_stage_pipe #(.DATA_W(8), .ADDR_W(10), .DEPTH(600), .CTRL_W(3)) u_small (
      .Clock(Clock), .Reset(Reset), .iValidEX(iValidEX), .iAluDataEX(iAluDataEX),
      .iOutMemSelect(iOutMemSelect), .iAddresReadNWrite(iAddresReadNWrite),
      .iControlAcum_EX(iControlAcum_EX), .iStallWB(iStallWB), .oStallMEM(stall_s),
      .oValidMEM(valid_s), .oDataToWB(data_s), .oControlAcum_MEM(ctrl_s), .oAddrFault(fault_s));

`ifdef MEM_CLEAR_EN
   logic       stall_c16, valid_c16, fault_c16;
   logic [7:0] data_c16;
   logic [2:0] ctrl_c16;

   mem_stage_pipe #(.DATA_W(8), .ADDR_W(10), .DEPTH(16), .CTRL_W(3)) u_clr (
      .Clock(Clock), .Reset(Reset), .iValidEX(iValidEX), .iAluDataEX(iAluDataEX),
      .iOutMemSelect(iOutMemSelect), .iAddresReadNWrite(iAddresReadNWrite),
      .iControlAcum_EX(iControlAcum_EX), .iStallWB(iStallWB), .oStallMEM(stall_c16),
      .oValidMEM(valid_c16), .oDataToWB(data_c16), .oControlAcum_MEM(ctrl_c16), .oAddrFault(fault_c16));
`endif

   typedef struct {
      logic       v;
      logic [1:0] sel;
      logic [7:0] alu;
      logic [9:0] addr;
      logic [2:0] ctrl;
      logic       st;
      logic       e_stall;
      logic       e_valid;
      logic [7:0] e_db;
      logic [7:0] e_ds;
      logic [2:0] e_ctrl;
      logic       e_fs;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [1:0] sel, input logic [7:0] alu, input logic [9:0] addr,
                      input logic [2:0] ctrl, input logic st, input logic e_stall, input logic e_valid,
                      input logic [7:0] e_db, input logic [7:0] e_ds, input logic [2:0] e_ctrl,
                      input logic e_fs);
      vec_t r;
      r.v = v; r.sel = sel; r.alu = alu; r.addr = addr; r.ctrl = ctrl; r.st = st;
      r.e_stall = e_stall; r.e_valid = e_valid; r.e_db = e_db; r.e_ds = e_ds;
      r.e_ctrl = e_ctrl; r.e_fs = e_fs;
      vt.push_back(r);
   endtask

   task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] alu,
                        input logic [9:0] addr, input logic [2:0] ctrl, input logic st);
      iValidEX = v; iOutMemSelect = sel; iAluDataEX = alu;
      iAddresReadNWrite = addr; iControlAcum_EX = ctrl; iStallWB = st;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid_b"}, 0, 32'(valid_b), 32'd0);
      chk({nm, "_data_b"},  0, 32'(data_b),  32'd0);
      chk({nm, "_ctrl_b"},  0, 32'(ctrl_b),  32'd0);
      chk({nm, "_fault_b"}, 0, 32'(fault_b), 32'd0);
      chk({nm, "_valid_s"}, 0, 32'(valid_s), 32'd0);
      chk({nm, "_fault_s"}, 0, 32'(fault_s), 32'd0);
   endtask

   initial begin
      // v sel alu addr ctrl st | stall valid data_b data_s ctrl fault_s
      add(1, 0, 8'h09, 10'd0,   3'd5, 0, 0, 1, 8'h09, 8'h09, 3'd5, 0);
      add(1, 2, 8'h09, 10'd0,   3'd1, 0, 0, 1, 8'h00, 8'h00, 3'd1, 0);
      add(1, 3, 8'h09, 10'd1,   3'd2, 0, 0, 1, 8'h09, 8'h09, 3'd2, 0);
      add(1, 3, 8'h08, 10'd1,   3'd3, 0, 0, 1, 8'h08, 8'h08, 3'd3, 0);
      add(1, 3, 8'h0F, 10'd2,   3'd4, 0, 0, 1, 8'h0F, 8'h0F, 3'd4, 0);
      add(1, 1, 8'hAA, 10'd1,   3'd6, 0, 0, 1, 8'h08, 8'h08, 3'd6, 0);
      add(1, 1, 8'hAA, 10'd2,   3'd7, 0, 0, 1, 8'h0F, 8'h0F, 3'd7, 0);
      add(1, 3, 8'h07, 10'd3,   3'd0, 0, 0, 1, 8'h07, 8'h07, 3'd0, 0);
      add(1, 1, 8'h00, 10'd3,   3'd1, 0, 0, 1, 8'h07, 8'h07, 3'd1, 0);
      add(0, 0, 8'h99, 10'd0,   3'd2, 0, 0, 0, 8'h07, 8'h07, 3'd1, 0);
      add(1, 3, 8'h11, 10'd5,   3'd0, 0, 0, 1, 8'h11, 8'h11, 3'd0, 0);
      add(1, 3, 8'h77, 10'd5,   3'd3, 1, 1, 1, 8'h11, 8'h11, 3'd0, 0);
      add(1, 3, 8'h77, 10'd5,   3'd3, 1, 1, 1, 8'h11, 8'h11, 3'd0, 0);
      add(0, 3, 8'h77, 10'd5,   3'd3, 0, 0, 0, 8'h11, 8'h11, 3'd0, 0);
      add(1, 1, 8'h00, 10'd5,   3'd2, 0, 0, 1, 8'h11, 8'h11, 3'd2, 0);
      add(1, 3, 8'h5A, 10'd4,   3'd5, 1, 1, 1, 8'h11, 8'h11, 3'd2, 0);
      add(1, 3, 8'h5A, 10'd4,   3'd5, 1, 1, 1, 8'h11, 8'h11, 3'd2, 0);
      add(1, 3, 8'h5A, 10'd4,   3'd5, 1, 1, 1, 8'h11, 8'h11, 3'd2, 0);
      add(1, 3, 8'h5A, 10'd4,   3'd5, 0, 0, 1, 8'h5A, 8'h5A, 3'd5, 0);
      add(1, 1, 8'h00, 10'd4,   3'd6, 0, 0, 1, 8'h5A, 8'h5A, 3'd6, 0);
      add(1, 3, 8'h33, 10'd700, 3'd1, 0, 0, 1, 8'h33, 8'h33, 3'd1, 1);
      add(1, 1, 8'h00, 10'd700, 3'd2, 0, 0, 1, 8'h33, 8'h00, 3'd2, 1);
      add(0, 0, 8'h00, 10'd0,   3'd0, 0, 0, 0, 8'h33, 8'h00, 3'd2, 1);
      add(1, 3, 8'h44, 10'd599, 3'd3, 0, 0, 1, 8'h44, 8'h44, 3'd3, 0);
      add(1, 1, 8'h00, 10'd700, 3'd4, 0, 0, 1, 8'h33, 8'h00, 3'd4, 1);
      add(1, 1, 8'h00, 10'd599, 3'd5, 1, 1, 1, 8'h33, 8'h00, 3'd4, 1);
      add(1, 1, 8'h00, 10'd599, 3'd5, 0, 0, 1, 8'h44, 8'h44, 3'd5, 0);

      // Asynchronous reset at start
      #2 Reset = 1'b0;
      #1 chk_zero("por");
      tick(); tick();
      @(negedge Clock) Reset = 1'b1;

`ifdef MEM_CLEAR_EN
      begin
         int n;
         // Abort the clear after 5 cycles, then expect a full 16-cycle restart
         for (int i = 0; i < 5; i++) tick();
         chk("clr_mid_stall", 0, 32'(stall_c16), 32'd1);
         @(negedge Clock) Reset = 1'b0;
         @(negedge Clock) Reset = 1'b1;
         #1;
         n = 0;
         while (stall_c16 && n < 100) begin
            chk("clr_valid", n, 32'(valid_c16), 32'd0);
            tick();
            n++;
         end
         chk("clr_cycles", 0, 32'(n), 32'd16);
         n = 0;
         while (stall_b && n < 1100) begin
            tick();
            n++;
         end
         chk("big_clear_done", 0, 32'(stall_b), 32'd0);
         for (int a = 0; a < 16; a++) begin
            drive(1, 1, 8'hEE, 10'(a), 3'd1, 0);
            tick();
            chk("clr_load", a, 32'(data_c16), 32'd0);
         end
         drive(0, 0, 8'h00, 10'd0, 3'd0, 0);
         tick();
      end
`endif

      foreach (vt[i]) begin
         drive(vt[i].v, vt[i].sel, vt[i].alu, vt[i].addr, vt[i].ctrl, vt[i].st);
         #1;
         chk("stall_b", i, 32'(stall_b), 32'(vt[i].e_stall));
         chk("stall_s", i, 32'(stall_s), 32'(vt[i].e_stall));
         tick();
         chk("valid_b", i, 32'(valid_b), 32'(vt[i].e_valid));
         chk("data_b",  i, 32'(data_b),  32'(vt[i].e_db));
         chk("ctrl_b",  i, 32'(ctrl_b),  32'(vt[i].e_ctrl));
         chk("fault_b", i, 32'(fault_b), 32'd0);
         chk("valid_s", i, 32'(valid_s), 32'(vt[i].e_valid));
         chk("data_s",  i, 32'(data_s),  32'(vt[i].e_ds));
         chk("ctrl_s",  i, 32'(ctrl_s),  32'(vt[i].e_ctrl));
         chk("fault_s", i, 32'(fault_s), 32'(vt[i].e_fs));
      end

      // Leave the small instance with the fault flag set, then reset between edges
      drive(1, 1, 8'h00, 10'd700, 3'd6, 0);
      tick();
      chk("pre_rst_fault_s", 0, 32'(fault_s), 32'd1);
      chk("pre_rst_ctrl_b",  0, 32'(ctrl_b),  32'd6);
      #2 Reset = 1'b0;
      #1 chk_zero("midrst");
      drive(0, 0, 8'h00, 10'd0, 3'd0, 0);
      tick();
      chk_zero("rst_hold");
      @(negedge Clock) Reset = 1'b1;

`ifndef MEM_CLEAR_EN
      // Memory is not cleared by reset
      drive(1, 1, 8'h00, 10'd4, 3'd3, 0);
      tick();
      chk("post_rst_load_b", 0, 32'(data_b),  32'h5A);
      chk("post_rst_load_s", 0, 32'(data_s),  32'h5A);
      chk("post_rst_valid",  0, 32'(valid_b), 32'd1);
      drive(0, 0, 8'h00, 10'd0, 3'd0, 0);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
